// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - video raster bundle from the timing generator
//
// Carries the registered raster outputs of video_timing_gen to the sink
// (the ADV7511 parallel input path and the frame-rate detector).
//   o_hsync        horizontal sync, polarity set by the generator
//   o_vsync        vertical sync, polarity set by the generator
//   o_de           active-video data enable
//   o_x, o_y       pixel column / active line, 0 outside active video
//   o_frame_start  one-cycle pulse at pixel (0,0)
//   o_line_start   one-cycle pulse at h = 0 of every line
// Modports: master = generator side (drives), slave = sink side (reads).
interface video_timing_gen_if;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_frame_start;
  logic        o_line_start;

  modport master (
    output o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_line_start
  );

  modport slave (
    input o_hsync, o_vsync, o_de, o_x, o_y, o_frame_start, o_line_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with 60/50 Hz front-porch select
//
// Ports:
//   clk        pixel clock, the only clock
//   reset      synchronous, active-high reset
//   i_mode_50  0 = 60 Hz line (H_FP), 1 = 50 Hz line (H_FP_50); latched only
//              during reset or at the last pixel of a frame
//   vid        raster outputs (video_timing_gen_if.master)
// All outputs are registered decodes of the counter value held before the
// edge, so pins lag the counters by exactly one clock.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_FP_50  = 440,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mode_50,
  video_timing_gen_if.master vid
);

  localparam logic [11:0] H_ACT       = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT       = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST_60   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] H_LAST_50   = 12'(H_ACTIVE + H_FP_50 + H_SYNC + H_BP - 1);
  localparam logic [11:0] HS_START_60 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_START_50 = 12'(H_ACTIVE + H_FP_50);
  localparam logic [11:0] HS_END_60   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HS_END_50   = 12'(H_ACTIVE + H_FP_50 + H_SYNC);
  localparam logic [11:0] V_LAST      = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] VS_ON_LINE  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_OFF_LINE = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ACT      = (HS_POL != 0);
  localparam logic        VS_ACT      = (VS_POL != 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        r_mode;

  logic [11:0] h_last;
  logic [11:0] hs_start;
  logic [11:0] hs_end;
  logic        de_now;
  logic        hs_now;
  logic        vs_now;

  always_comb begin
    h_last   = r_mode ? H_LAST_50   : H_LAST_60;
    hs_start = r_mode ? HS_START_50 : HS_START_60;
    hs_end   = r_mode ? HS_END_50   : HS_END_60;
    de_now   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_now   = (h_cnt >= hs_start) && (h_cnt < hs_end);
    // vsync window opens and closes at the hsync leading edge of its
    // first and first-after-last lines, so both edges share a clock.
    vs_now   = ((v_cnt > VS_ON_LINE) || ((v_cnt == VS_ON_LINE) && (h_cnt >= hs_start))) &&
               ((v_cnt < VS_OFF_LINE) || ((v_cnt == VS_OFF_LINE) && (h_cnt < hs_start)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt             <= '0;
      v_cnt             <= '0;
      r_mode            <= i_mode_50;
      vid.o_hsync       <= ~HS_ACT;
      vid.o_vsync       <= ~VS_ACT;
      vid.o_de          <= 1'b0;
      vid.o_x           <= '0;
      vid.o_y           <= '0;
      vid.o_frame_start <= 1'b0;
      vid.o_line_start  <= 1'b0;
    end else begin
      vid.o_hsync       <= hs_now ? HS_ACT : ~HS_ACT;
      vid.o_vsync       <= vs_now ? VS_ACT : ~VS_ACT;
      vid.o_de          <= de_now;
      vid.o_x           <= de_now ? h_cnt : 12'd0;
      vid.o_y           <= de_now ? v_cnt : 12'd0;
      vid.o_frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      vid.o_line_start  <= (h_cnt == 12'd0);

      if (h_cnt == h_last) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt  <= '0;
          // Mode only changes between frames so no frame mixes line lengths.
          r_mode <= i_mode_50;
        end else begin
          v_cnt <= v_cnt + 12'd1;
        end
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

  // Reduced raster: 60 Hz line 28, 50 Hz line 34, 13 lines per frame.
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 4;
  localparam int H_FP_50  = 10;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 5;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;

  logic clk = 1'b0;
  logic reset;
  logic i_mode_50;

  video_timing_gen_if vif();
  video_timing_gen_if vif_n();

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_FP_50(H_FP_50), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1), .VS_POL(1)
  ) dut (
    .clk(clk), .reset(reset), .i_mode_50(i_mode_50), .vid(vif)
  );

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_FP_50(H_FP_50), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(0), .VS_POL(0)
  ) dut_n (
    .clk(clk), .reset(reset), .i_mode_50(i_mode_50), .vid(vif_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        ls;
  } vec_t;

  vec_t tbl[18];
  int   n_vec = 0;
  int   n_err = 0;
  int   t_now = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Steps from a frame_start sample to the next one, recording the first
  // hsync-active and line_start offsets plus de/vsync activity counts.
  task automatic measure(output int period, output int hs_off, output int line_len,
                         output int de_cnt, output int vs_cnt);
    period = 0; hs_off = -1; line_len = -1; de_cnt = 0; vs_cnt = 0;
    for (int n = 1; n <= 1000; n++) begin
      step(1);
      if (hs_off < 0 && vif.o_hsync) hs_off = n;
      if (line_len < 0 && vif.o_line_start) line_len = n;
      if (vif.o_de) de_cnt++;
      if (vif.o_vsync) vs_cnt++;
      if (vif.o_frame_start) begin
        period = n;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out"}, {vif.o_hsync, vif.o_vsync, vif.o_de, vif.o_x, vif.o_y,
                           vif.o_frame_start, vif.o_line_start}, 32'd0);
    check({name, "_pol"}, {vif_n.o_hsync, vif_n.o_vsync, vif_n.o_de, vif_n.o_frame_start},
          32'b1100);
  endtask

  initial begin
    int period, hs_off, line_len, de_cnt, vs_cnt;

    //            t    hs vs de  x    y   fs ls
    tbl[0]  = '{  1,   0, 0, 1,  0,   0,  1, 1};
    tbl[1]  = '{  2,   0, 0, 1,  1,   0,  0, 0};
    tbl[2]  = '{ 16,   0, 0, 1, 15,   0,  0, 0};
    tbl[3]  = '{ 17,   0, 0, 0,  0,   0,  0, 0};
    tbl[4]  = '{ 20,   0, 0, 0,  0,   0,  0, 0};
    tbl[5]  = '{ 21,   1, 0, 0,  0,   0,  0, 0};
    tbl[6]  = '{ 23,   1, 0, 0,  0,   0,  0, 0};
    tbl[7]  = '{ 24,   0, 0, 0,  0,   0,  0, 0};
    tbl[8]  = '{ 29,   0, 0, 1,  0,   1,  0, 1};
    tbl[9]  = '{ 34,   0, 0, 1,  5,   1,  0, 0};
    tbl[10] = '{144,   0, 0, 1,  3,   5,  0, 0};
    tbl[11] = '{169,   0, 0, 0,  0,   0,  0, 1};
    tbl[12] = '{244,   0, 0, 0,  0,   0,  0, 0};
    tbl[13] = '{245,   1, 1, 0,  0,   0,  0, 0};
    tbl[14] = '{300,   0, 1, 0,  0,   0,  0, 0};
    tbl[15] = '{301,   1, 0, 0,  0,   0,  0, 0};
    tbl[16] = '{364,   0, 0, 0,  0,   0,  0, 0};
    tbl[17] = '{365,   0, 0, 1,  0,   0,  1, 1};

    reset = 1'b1;
    i_mode_50 = 1'b0;
    step(5);
    check_reset_state("reset");

    reset = 1'b0;
    t_now = 0;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].t - t_now);
      t_now = tbl[i].t;
      check($sformatf("vec%0d", i),
            {vif.o_hsync, vif.o_vsync, vif.o_de, vif.o_x, vif.o_y, vif.o_frame_start, vif.o_line_start},
            {tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].x, tbl[i].y, tbl[i].fs, tbl[i].ls});
      check($sformatf("pol%0d", i),
            {vif_n.o_hsync, vif_n.o_vsync, vif_n.o_de, vif_n.o_x, vif_n.o_y},
            {~tbl[i].hs, ~tbl[i].vs, tbl[i].de, tbl[i].x, tbl[i].y});
    end

    // Full 60 Hz frame.
    measure(period, hs_off, line_len, de_cnt, vs_cnt);
    check("f60_period", period, 364);
    check("f60_hs_off", hs_off, 20);
    check("f60_line",   line_len, 28);
    check("f60_de",     de_cnt, 96);
    check("f60_vs",     vs_cnt, 56);

    // Mode switch mid-frame takes effect only at the next frame.
    step(90);
    i_mode_50 = 1'b1;
    measure(period, hs_off, line_len, de_cnt, vs_cnt);
    check("sw_remain", period, 274);
    measure(period, hs_off, line_len, de_cnt, vs_cnt);
    check("f50_period", period, 442);
    check("f50_hs_off", hs_off, 26);
    check("f50_line",   line_len, 34);
    check("f50_de",     de_cnt, 96);
    check("f50_vs",     vs_cnt, 68);

    // Reset mid-frame, inside the vsync/hsync pulses (line 8, pixel 27).
    i_mode_50 = 1'b0;
    step(299);
    check("pre_rst_sync", {vif.o_hsync, vif.o_vsync}, 2'b11);
    check("pre_rst_pol",  {vif_n.o_hsync, vif_n.o_vsync}, 2'b00);
    reset = 1'b1;
    step(1);
    check_reset_state("mid_rst");
    reset = 1'b0;
    step(1);
    check("restart", {vif.o_frame_start, vif.o_line_start, vif.o_de, vif.o_x, vif.o_y},
          {1'b1, 1'b1, 1'b1, 12'd0, 12'd0});
    measure(period, hs_off, line_len, de_cnt, vs_cnt);
    check("post_rst_period", period, 364);
    check("post_rst_hs_off", hs_off, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
